// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks (i, j, k) over an N x N multiply C = A x B.
// It issues registered reads to A and B, accumulates one dot product per
// output element, and then writes that element to C.
module matmul_sequencer #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 6,
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          read_A,
    output logic [AW-1:0] read_address_A,
    input  logic [DW-1:0] data_A,
    output logic          read_B,
    output logic [AW-1:0] read_address_B,
    input  logic [DW-1:0] data_B,
    output logic          write_C,
    output logic [AW-1:0] write_address_C,
    output logic [CW-1:0] write_value_C
);
    // Counter width is kept at 1 bit or more so that N=1 still builds.
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [AW-1:0] NA   = AW'(N);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_WRITE, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_i, r_j, r_k;
    logic [IW-1:0] w_i_nxt, w_j_nxt, w_k_nxt;
    logic [CW-1:0] r_acc, w_acc_nxt, w_prod;

    logic          r_busy, r_done, r_read_A, r_read_B, r_write_C;
    logic [AW-1:0] r_addr_A, r_addr_B, r_addr_C;
    logic [CW-1:0] r_value_C;

    // Row-major linear address of element (r, c).
    function automatic logic [AW-1:0] lin(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return AW'(r) * NA + AW'(c);
    endfunction

    // Both operands are zero-extended to CW first, so the product cannot wrap.
    assign w_prod = CW'(data_A) * CW'(data_B);

    // Next-state, counter and accumulator logic.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                w_i_nxt   = '0;
                w_j_nxt   = '0;
                w_k_nxt   = '0;
                w_acc_nxt = '0;
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = S_ACC;
            S_ACC: begin
                // Read data from the FETCH cycle is valid here.
                w_acc_nxt = r_acc + w_prod;
                if (r_k == LAST) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_k_nxt     = r_k + 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WRITE: begin
                w_acc_nxt = '0;
                w_k_nxt   = '0;
                if (r_j != LAST) begin
                    w_j_nxt     = r_j + 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (r_i != LAST) begin
                    w_j_nxt     = '0;
                    w_i_nxt     = r_i + 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_i_nxt     = '0;
                w_j_nxt     = '0;
                w_k_nxt     = '0;
                w_acc_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Outputs are registered from the next state, so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_read_A  <= 1'b0;
            r_read_B  <= 1'b0;
            r_write_C <= 1'b0;
            r_addr_A  <= '0;
            r_addr_B  <= '0;
            r_addr_C  <= '0;
            r_value_C <= '0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_read_A  <= (w_state_nxt == S_FETCH);
            r_read_B  <= (w_state_nxt == S_FETCH);
            r_write_C <= (w_state_nxt == S_WRITE);
            r_addr_A  <= (w_state_nxt == S_FETCH) ? lin(w_i_nxt, w_k_nxt) : '0;
            r_addr_B  <= (w_state_nxt == S_FETCH) ? lin(w_k_nxt, w_j_nxt) : '0;
            r_addr_C  <= (w_state_nxt == S_WRITE) ? lin(w_i_nxt, w_j_nxt) : '0;
            // The value holds between writes; it loads the completed sum on ACC->WRITE.
            if (w_state_nxt == S_WRITE) r_value_C <= w_acc_nxt;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign read_A          = r_read_A;
    assign read_B          = r_read_B;
    assign write_C         = r_write_C;
    assign read_address_A  = r_addr_A;
    assign read_address_B  = r_addr_B;
    assign write_address_C = r_addr_C;
    assign write_value_C   = r_value_C;

endmodule
